// File: rtl/pll_lock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_seq_pkg
// Brief   : Shared types and constants for the PLL lock sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam int c_lost_cnt_w  = 8;
    localparam int c_retry_cnt_w = 2;

    // Bits needed to count 0 .. max(a, b, c) - 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_sequencer_if
// Brief   : PLL-side and system-side signals of the PLL lock sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic                          relock_req;
    logic                          pll_locked;
    logic                          pll_rst;
    logic                          sys_rst_n;
    logic                          ready;
    logic                          fault;
    logic [c_retry_cnt_w-1:0]      retry_cnt;
    logic [c_lost_cnt_w-1:0]       lost_cnt;
    logic [2:0]                    state;

    modport master (
        output relock_req, pll_locked,
        input  pll_rst, sys_rst_n, ready, fault, retry_cnt, lost_cnt, state
    );

    modport slave (
        input  relock_req, pll_locked,
        output pll_rst, sys_rst_n, ready, fault, retry_cnt, lost_cnt, state
    );

endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module  : sync2
// Brief   : Generic two-flop synchroniser with asynchronous active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_sequencer
// Brief   : Sequences the core PLL through reset, lock qualification, run,
//           relock and fault; holds the system reset until lock is trusted.
// Revision: 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3
) (
    input wire logic              refclk,
    input wire logic              rst_n,
    pll_lock_sequencer_if.slave   bus
);

    localparam int c_cnt_w = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(TIMEOUT_CYCLES - 1);

    pll_state_t                r_state;
    pll_state_t                w_next_state;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        r_tmo;
    logic [c_retry_cnt_w-1:0]  r_retry_cnt;
    logic [c_retry_cnt_w-1:0]  w_retry_inc;
    logic [c_lost_cnt_w-1:0]   r_lost_cnt;
    logic                      r_pll_rst;
    logic                      r_sys_rst_n;
    logic                      r_ready;
    logic                      r_fault;
    logic                      w_lk;
    logic                      w_in_lock_wait;
    logic                      w_tmo_hit;
    logic                      w_retry_exhausted;
    logic                      w_timeout;
    logic                      w_lost;

    sync2 #(
        .WIDTH (1)
    ) u_lk_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_lk)
    );

    assign w_in_lock_wait    = (r_state == WAIT_LOCK) || (r_state == STABLE);
    assign w_tmo_hit         = w_in_lock_wait && (r_tmo == c_tmo_last);
    assign w_retry_inc       = (r_retry_cnt == 2'd3) ? 2'd3 : r_retry_cnt + 2'd1;
    assign w_retry_exhausted = (int'(w_retry_inc) >= MAX_RETRY);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PLL_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // relock_req overrides everything; inside STABLE a lock drop beats a
    // coincident timeout, which is then taken from WAIT_LOCK a cycle later.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_lost       = 1'b0;
        if (bus.relock_req) begin
            w_next_state = PLL_RST;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == c_rst_last) w_next_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_tmo_hit) begin
                        w_timeout    = 1'b1;
                        w_next_state = w_retry_exhausted ? FAULT : PLL_RST;
                    end else if (w_lk) begin
                        w_next_state = STABLE;
                    end
                end
                STABLE: begin
                    if (!w_lk) begin
                        w_next_state = WAIT_LOCK;
                    end else if (w_tmo_hit) begin
                        w_timeout    = 1'b1;
                        w_next_state = w_retry_exhausted ? FAULT : PLL_RST;
                    end else if (r_cnt == c_stable_last) begin
                        w_next_state = RUN;
                    end
                end
                RUN: begin
                    if (!w_lk) begin
                        w_lost       = 1'b1;
                        w_next_state = PLL_RST;
                    end
                end
                FAULT: begin
                    w_next_state = FAULT;
                end
                default: begin
                    w_next_state = PLL_RST;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_retry_cnt <= '0;
            r_lost_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            if (bus.relock_req || (w_next_state != r_state)) begin
                r_cnt <= '0;
            end else if ((r_state == PLL_RST) || (r_state == STABLE)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            // tmo spans WAIT_LOCK and STABLE together; it saturates so a
            // deferred timeout is still seen on the following cycle.
            if (w_in_lock_wait &&
                ((w_next_state == WAIT_LOCK) || (w_next_state == STABLE))) begin
                if (!w_tmo_hit) r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end

            if (bus.relock_req) begin
                r_retry_cnt <= '0;
            end else if (w_timeout) begin
                r_retry_cnt <= w_retry_inc;
            end else if (w_next_state == RUN) begin
                r_retry_cnt <= '0;
            end

            if (w_lost && (r_lost_cnt != '1)) begin
                r_lost_cnt <= r_lost_cnt + 1'b1;
            end

            r_pll_rst   <= (w_next_state == PLL_RST) || (w_next_state == FAULT);
            r_sys_rst_n <= (w_next_state == RUN);
            r_ready     <= (w_next_state == RUN);
            r_fault     <= (w_next_state == FAULT);
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.ready     = r_ready;
    assign bus.fault     = r_fault;
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.lost_cnt  = r_lost_cnt;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_lock_sequencer
// Brief   : Self-checking bench for pll_lock_sequencer (scoreboard of timed
//           events plus a table of power-up lock scenarios).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int c_rst    = 16;
    localparam int c_stable = 1024;
    localparam int c_tmo    = 4000;
    localparam int c_retry  = 3;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;

    pll_lock_sequencer_if bus_if();

    pll_lock_sequencer #(
        .RST_CYCLES     (c_rst),
        .STABLE_CYCLES  (c_stable),
        .TIMEOUT_CYCLES (c_tmo),
        .MAX_RETRY      (c_retry)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    always #10 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int base = 0;
    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        string name;
        int    exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int rise_at;
        int glitch_off;
        int glitch_len;
        int exp_fall;
        int exp_ready;
    } vec_t;
    vec_t vecs[4];

    task automatic expect_val(input string name, input int exp);
        sb_q.push_back('{name, exp});
    endtask

    task automatic observe(input int act);
        sb_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $display("FAIL scoreboard_empty: got %0d, expected nothing", act);
        end else begin
            e = sb_q.pop_front();
            if (act != e.exp) begin
                n_mis++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        expect_val(name, exp);
        observe(act);
    endtask

    task automatic check_outputs(input string tag, input int prst, input int srst,
                                 input int rdy, input int flt, input int rtr,
                                 input int lost, input int st);
        check({tag, ".pll_rst"},   int'(bus_if.pll_rst),   prst);
        check({tag, ".sys_rst_n"}, int'(bus_if.sys_rst_n), srst);
        check({tag, ".ready"},     int'(bus_if.ready),     rdy);
        check({tag, ".fault"},     int'(bus_if.fault),     flt);
        check({tag, ".retry_cnt"}, int'(bus_if.retry_cnt), rtr);
        check({tag, ".lost_cnt"},  int'(bus_if.lost_cnt),  lost);
        check({tag, ".state"},     int'(bus_if.state),     st);
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return bus_if.ready;
            1:       return bus_if.pll_rst;
            2:       return bus_if.fault;
            default: return bus_if.sys_rst_n;
        endcase
    endfunction

    task automatic wait_level(input int which, input bit val, input int budget,
                              output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge refclk);
            if (sig(which) == val) begin
                at = cyc - base;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst_n             = 1'b0;
        bus_if.pll_locked = 1'b0;
        bus_if.relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        check_outputs("reset", 1, 0, 0, 0, 0, 0, int'(PLL_RST));
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, at, d, c, got_fall, got_ready, sys_at, retry_at, state_at;
        int rises[2];
        int rise_retry[2];
        int nr, got_fault, retry_f, zeros;
        bit prev_pr;

        vecs[0] = '{100,   0, 0, 16, 1127};
        vecs[1] = '{100, 502, 3, 16, 1632};
        vecs[2] = '{  5,   0, 0, 16, 1041};
        vecs[3] = '{100, 200, 1, 16, 1328};

        bus_if.pll_locked = 1'b0;
        bus_if.relock_req = 1'b0;

        // Power-up lock scenarios, each from a fresh reset.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            expect_val($sformatf("v%0d.pll_rst_fall", v), vecs[v].exp_fall);
            expect_val($sformatf("v%0d.ready_rise", v), vecs[v].exp_ready);
            expect_val($sformatf("v%0d.sys_rst_n_at_ready", v), 1);
            expect_val($sformatf("v%0d.retry_at_ready", v), 0);
            expect_val($sformatf("v%0d.state_at_ready", v), int'(RUN));
            got_fall = -1; got_ready = -1; sys_at = -1; retry_at = -1; state_at = -1;
            for (int k = 0; k < 3000 && got_ready < 0; k++) begin
                @(negedge refclk);
                r = cyc - base;
                if (got_fall < 0 && !bus_if.pll_rst) got_fall = r;
                if (bus_if.ready) begin
                    got_ready = r;
                    sys_at    = int'(bus_if.sys_rst_n);
                    retry_at  = int'(bus_if.retry_cnt);
                    state_at  = int'(bus_if.state);
                end
                if (r == vecs[v].rise_at) bus_if.pll_locked = 1'b1;
                if (vecs[v].glitch_len > 0 && r == vecs[v].rise_at + vecs[v].glitch_off)
                    bus_if.pll_locked = 1'b0;
                if (vecs[v].glitch_len > 0 &&
                    r == vecs[v].rise_at + vecs[v].glitch_off + vecs[v].glitch_len)
                    bus_if.pll_locked = 1'b1;
            end
            observe(got_fall);
            observe(got_ready);
            observe(sys_at);
            observe(retry_at);
            observe(state_at);
        end

        // Lock loss in RUN, then full re-qualification.
        @(negedge refclk);
        d = cyc - base;
        bus_if.pll_locked = 1'b0;
        expect_val("loss.ready_fall", d + 3);
        wait_level(0, 1'b0, 20, at);
        observe(at);
        check_outputs("loss", 1, 0, 0, 0, 0, 1, int'(PLL_RST));
        while (cyc - base < d + 30) @(negedge refclk);
        bus_if.pll_locked = 1'b1;
        expect_val("loss.ready_rerise", d + 30 + 3 + c_stable);
        wait_level(0, 1'b1, 2000, at);
        observe(at);
        check("loss.sys_rst_n_rerise", int'(bus_if.sys_rst_n), 1);

        // relock_req coincident with a lock drop seen in RUN.
        @(negedge refclk);
        d = cyc - base;
        bus_if.pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        check("relock.ready_before", int'(bus_if.ready), 1);
        bus_if.relock_req = 1'b1;
        @(negedge refclk);
        bus_if.relock_req = 1'b0;
        check_outputs("relock", 1, 0, 0, 0, 0, 1, int'(PLL_RST));
        expect_val("relock.pll_rst_fall", d + 3 + c_rst);
        wait_level(1, 1'b0, 40, at);
        observe(at);
        check("relock.lost_after", int'(bus_if.lost_cnt), 1);

        // Asynchronous reset in the middle of STABLE.
        @(negedge refclk);
        bus_if.pll_locked = 1'b1;
        repeat (300) @(negedge refclk);
        check("arst.state_before", int'(bus_if.state), int'(STABLE));
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("arst", 1, 0, 0, 0, 0, 0, int'(PLL_RST));

        // Lock never arrives: three timeouts into FAULT.
        do_reset();
        expect_val("tmo.rise0", 1 * (c_rst + c_tmo));
        expect_val("tmo.retry0", 1);
        expect_val("tmo.rise1", 2 * (c_rst + c_tmo));
        expect_val("tmo.retry1", 2);
        expect_val("tmo.fault_rise", 3 * (c_rst + c_tmo));
        expect_val("tmo.retry_fault", 3);
        nr = 0; got_fault = -1; retry_f = -1; prev_pr = 1'b1;
        rises[0] = -1; rises[1] = -1; rise_retry[0] = -1; rise_retry[1] = -1;
        for (int k = 0; k < 13000; k++) begin
            @(negedge refclk);
            r = cyc - base;
            if (bus_if.fault) begin
                got_fault = r;
                retry_f   = int'(bus_if.retry_cnt);
                break;
            end
            if (!prev_pr && bus_if.pll_rst && nr < 2) begin
                rises[nr]      = r;
                rise_retry[nr] = int'(bus_if.retry_cnt);
                nr++;
            end
            prev_pr = bus_if.pll_rst;
        end
        observe(rises[0]);
        observe(rise_retry[0]);
        observe(rises[1]);
        observe(rise_retry[1]);
        observe(got_fault);
        observe(retry_f);
        zeros = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge refclk);
            if (!bus_if.pll_rst) zeros++;
        end
        check("fault.pll_rst_low_cycles", zeros, 0);
        check_outputs("fault", 1, 0, 0, 1, 3, 0, int'(FAULT));

        // relock_req leaves FAULT.
        @(negedge refclk);
        c = cyc - base;
        bus_if.relock_req = 1'b1;
        @(negedge refclk);
        bus_if.relock_req = 1'b0;
        check_outputs("unfault", 1, 0, 0, 0, 0, 0, int'(PLL_RST));
        expect_val("unfault.pll_rst_fall", c + 1 + c_rst);
        wait_level(1, 1'b0, 40, at);
        observe(at);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the core PLL (50 MHz reference in; 112 MHz and 56 MHz out) through power-up, lock, relock and fault recovery.
- Drives the PLL reset pulse and qualifies the PLL lock signal with a synchroniser and a stability filter.
- Holds the system reset asserted until the PLL outputs are trustworthy.
- Runs on the free-running reference clock, because PLL outputs are not valid before lock. Sits beside the PLL wrapper in the top level.

Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse, in refclk cycles (min 1).
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before release (min 1).
- TIMEOUT_CYCLES, 50000: maximum cycles from PLL reset release to qualified lock (1 ms at 50 MHz).
- MAX_RETRY, 3: consecutive timeouts tolerated before declaring a fault (min 1).

Ports:
- refclk  in  1  reference clock, 50 MHz, sole clock of the block.
- rst_n  in  1  asynchronous active-low reset.
- relock_req  in  1  single-cycle request to restart the PLL (e.g. after a clock reconfiguration); synchronous to refclk.
- pll_locked  in  1  raw PLL lock output; asynchronous to refclk.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low system reset. Consumers resynchronise it into each PLL clock domain.
- ready  out  1  high only while in RUN.
- fault  out  1  high only while in FAULT.
- retry_cnt  out  2  consecutive timeout count; saturates at 3.
- lost_cnt  out  8  count of lock losses seen in RUN; saturating; cleared only by rst_n.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset: one clock, refclk. Reset is asynchronous, active-low (rst_n).
- Reset values: pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lost_cnt=0, state=PLL_RST. All counters 0. Sync flops 0.
- Lock synchronisation: pll_locked passes through a 2-flop synchroniser to give lk. All decisions use lk, so 2 cycles of latency.
- One shared cycle counter, cnt, wide enough for max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES). It is cleared on every state entry. A separate timeout counter, tmo, is cleared on entry to WAIT_LOCK only.
- PLL_RST (0): pll_rst=1, sys_rst_n=0. When cnt reaches RST_CYCLES-1, go to WAIT_LOCK. The pulse is exactly RST_CYCLES cycles.
- WAIT_LOCK (1): pll_rst=0. tmo increments each cycle.
  - lk=1 -> STABLE.
  - tmo reaches TIMEOUT_CYCLES-1 -> timeout.
- STABLE (2): tmo keeps counting; cnt counts while lk=1.
  - lk=0 -> WAIT_LOCK with cnt cleared and tmo NOT cleared.
  - cnt reaches STABLE_CYCLES-1 -> RUN.
  - Timeout in STABLE applies as in WAIT_LOCK.
- Timeout handling: retry_cnt increments (saturating).
  - If the new value is >= MAX_RETRY -> FAULT.
  - Otherwise -> PLL_RST.
- RUN (3): sys_rst_n=1 and ready=1, registered on the transition; retry_cnt cleared.
  - lk=0 -> sys_rst_n=0 on the next edge, lost_cnt increments (saturating), go to PLL_RST.
- FAULT (4): pll_rst=1 (PLL held in reset), sys_rst_n=0, fault=1. Exit only via relock_req or rst_n.
- relock_req in any state: highest priority, overriding timeout and lock loss in the same cycle.
  - Next state is PLL_RST; retry_cnt=0; lost_cnt is unchanged.
  - sys_rst_n falls on the next edge.
- Simultaneous lk=0 and timeout in STABLE: lk=0 takes precedence, giving WAIT_LOCK; the timeout is evaluated next cycle.
- sys_rst_n deassertion is always synchronous to refclk; assertion via rst_n is asynchronous.
- Unused state encodings go to PLL_RST.

Decomposition:
- Shared package pll_seq_pkg: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT; 3 bits), counter-width function, lost_cnt width constant.
- One sub-module, sync2: a generic 2-flop synchroniser with asynchronous active-low reset. It is reused for lk and later for the per-domain sys_rst_n resynchronisers.

Test Plan:
- Power-up with pll_locked rising 100 cycles after rst_n release: pll_rst high for exactly 16 cycles. ready rises 2+1024 cycles after pll_locked is first sampled (plus the state transition). sys_rst_n rises together with ready.
- Glitch on pll_locked during STABLE (low for 3 cycles at cnt=500): cnt restarts, so ready rises 1024 cycles after the glitch ends. retry_cnt stays 0.
- pll_locked held low: 3 timeouts, each 16+50000 cycles apart. fault=1 and retry_cnt=3; pll_rst stays 1. A later relock_req returns the block to PLL_RST with retry_cnt=0.
- Lock loss in RUN: pll_locked drops, so sys_rst_n=0 and ready=0 within 3 cycles, and lost_cnt goes 0->1. The full sequence then completes again.
- relock_req in RUN coincident with a lock drop: one transition to PLL_RST, lost_cnt unchanged, retry_cnt=0.
- rst_n asserted mid-STABLE: all outputs return to reset values asynchronously, without waiting for refclk. lost_cnt=0.
